overture_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the 8-bit OVERTURE CPU.
- Owns the program counter and drives the address of the asynchronous-read program ROM.
- Captures each returned byte into an instruction register and presents it to the decoder over a valid/ready handshake.
- Handles jumps (flush), run/pause, halt and end-of-program.

---
 rtl/overture_fetch_ctrl_if.sv | 62 ++++++
 rtl/overture_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_overture_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/overture_fetch_ctrl_if.sv
// Fetch-to-environment bundle: ROM address/data, control pulses, and instruction handshake.
// Latency: pure wiring, no storage.
// Backpressure: instr_ready from the decoder side stalls instr_valid on the master side.
// Optional: OVERTURE_FETCH_STEP_EN adds the single-step pulse input.
interface overture_fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              run;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_target;
  logic              halt_req;
  logic [7:0]        instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;
`ifdef OVERTURE_FETCH_STEP_EN
  logic              step;
`endif

  // The fetch controller side
  modport master (
    output rom_addr,
    input  rom_data,
    input  run,
    input  jump_en,
    input  jump_target,
    input  halt_req,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    output halted,
    output fetch_count
`ifdef OVERTURE_FETCH_STEP_EN
    , input step
`endif
  );

  // ROM, control and decoder side
  modport slave (
    input  rom_addr,
    output rom_data,
    output run,
    output jump_en,
    output jump_target,
    output halt_req,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    input  halted,
    input  fetch_count
`ifdef OVERTURE_FETCH_STEP_EN
    , output step
`endif
  );
endinterface

// File: rtl/overture_fetch_ctrl.sv
// OVERTURE instruction-fetch sequencer: owns pc, drives async ROM, registers instr for the decoder.
// Latency: rom_addr to instr is 1 cycle; 1 instr/cycle with instr_ready held high.
// Backpressure: a valid, unaccepted instr stalls pc and fetching until instr_ready.
// Optional: OVERTURE_FETCH_STEP_EN gates each fetch in FETCH with a one-cycle step pulse.
module overture_fetch_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 255,
  parameter int WRAP      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  overture_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED, S_END} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic [7:0]        instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              instr_valid_q;
  logic [CNT_W-1:0]  fetch_count_q;
  logic              fetch_fire;
  logic              consume;
  logic              halted_c;
  logic              step_ok;

`ifdef OVERTURE_FETCH_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state: halt beats jump, jump beats run/fetch sequencing
  always_comb begin
    state_nxt = state;
    if (bus.halt_req) begin
      state_nxt = S_HALTED;
    end else if (bus.jump_en) begin
      state_nxt = bus.run ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.run) state_nxt = S_FETCH;
        S_FETCH: begin
          if (!bus.run)
            state_nxt = S_IDLE;
          else if (fetch_fire && (WRAP == 0) && (pc == LAST))
            state_nxt = S_END;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Outputs of the FSM: fetch strobe, consume strobe, halted flag, next sequential pc
  always_comb begin
    fetch_fire = (state == S_FETCH) && bus.run && (!instr_valid_q || bus.instr_ready)
                 && step_ok && !bus.halt_req && !bus.jump_en;
    consume    = instr_valid_q && bus.instr_ready;
    halted_c   = (state == S_HALTED) || (state == S_END);
    // Without wrap, pc parks on the last address; at or beyond it, wrap to 0
    pc_inc = pc + 1'b1;
    if ((WRAP == 0) && (pc == LAST))
      pc_inc = pc;
    else if (pc >= LAST)
      pc_inc = '0;
  end

  // Datapath: pc, instruction register, valid flag and saturating fetch counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else if (bus.halt_req) begin
      instr_valid_q <= 1'b0;
    end else if (bus.jump_en) begin
      pc            <= bus.jump_target;
      instr_valid_q <= 1'b0;
    end else if (fetch_fire) begin
      pc            <= pc_inc;
      instr_q       <= bus.rom_data;
      instr_pc_q    <= pc;
      instr_valid_q <= 1'b1;
      if (!(&fetch_count_q)) fetch_count_q <= fetch_count_q + 1'b1;
    end else if (consume) begin
      instr_valid_q <= 1'b0;
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_count = fetch_count_q;
  assign bus.halted      = halted_c;

endmodule

// File: tb/tb_overture_fetch_ctrl.sv
// Directed bench for overture_fetch_ctrl: default wrapping instance plus a WRAP=0, LAST_ADDR=3 instance.
// ROM model: ROM[i] = i + 0x10 (mod 256), combinational from rom_addr.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_overture_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  overture_fetch_ctrl_if #(.ADDR_W(8), .CNT_W(16)) bus_a ();
  overture_fetch_ctrl_if #(.ADDR_W(8), .CNT_W(16)) bus_b ();

  overture_fetch_ctrl #(.ADDR_W(8), .LAST_ADDR(255), .WRAP(1), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  overture_fetch_ctrl #(.ADDR_W(8), .LAST_ADDR(3), .WRAP(0), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  assign bus_a.rom_data = bus_a.rom_addr + 8'h10;
  assign bus_b.rom_data = bus_b.rom_addr + 8'h10;

`ifdef OVERTURE_FETCH_STEP_EN
  assign bus_a.step = 1'b1;
  assign bus_b.step = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.run = 1'b0; bus_a.jump_en = 1'b0; bus_a.jump_target = 8'h00;
    bus_a.halt_req = 1'b0; bus_a.instr_ready = 1'b0;
    bus_b.run = 1'b0; bus_b.jump_en = 1'b0; bus_b.jump_target = 8'h00;
    bus_b.halt_req = 1'b0; bus_b.instr_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("rst_addr",  32'(bus_a.rom_addr),    32'h00);
    chk("rst_instr", 32'(bus_a.instr),       32'h00);
    chk("rst_cnt",   32'(bus_a.fetch_count), 32'd0);
    chk("rst_halt",  32'(bus_a.halted),      32'd0);
    tick();
    tick();
    rst_a = 1'b1;
    bus_a.run = 1'b1;
    bus_a.instr_ready = 1'b1;

    // IDLE -> FETCH transition, no fetch yet
    tick();
    chk("enter_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("enter_addr",  32'(bus_a.rom_addr),    32'h00);
    tick();
    chk("f0_instr", 32'(bus_a.instr),       32'h10);
    chk("f0_pc",    32'(bus_a.instr_pc),    32'h00);
    chk("f0_valid", 32'(bus_a.instr_valid), 32'd1);
    tick();
    chk("f1_instr", 32'(bus_a.instr), 32'h11);
    tick();
    chk("f2_instr", 32'(bus_a.instr),       32'h12);
    chk("f2_cnt",   32'(bus_a.fetch_count), 32'd3);
    chk("f2_addr",  32'(bus_a.rom_addr),    32'h03);

    // Backpressure holds everything
    bus_a.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_instr", 32'(bus_a.instr),       32'h12);
      chk("bp_addr",  32'(bus_a.rom_addr),    32'h03);
      chk("bp_cnt",   32'(bus_a.fetch_count), 32'd3);
    end
    bus_a.instr_ready = 1'b1;
    tick();
    chk("bp_rel_instr", 32'(bus_a.instr),       32'h13);
    chk("bp_rel_pc",    32'(bus_a.instr_pc),    32'h03);
    chk("bp_rel_cnt",   32'(bus_a.fetch_count), 32'd4);

    // Jump flushes the pending instr
    bus_a.jump_en = 1'b1;
    bus_a.jump_target = 8'h40;
    tick();
    bus_a.jump_en = 1'b0;
    chk("jmp_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("jmp_addr",  32'(bus_a.rom_addr),    32'h40);
    chk("jmp_cnt",   32'(bus_a.fetch_count), 32'd4);
    tick();
    chk("jmp_instr", 32'(bus_a.instr),       32'h50);
    chk("jmp_pc",    32'(bus_a.instr_pc),    32'h40);
    chk("jmp_cnt2",  32'(bus_a.fetch_count), 32'd5);

    // Halt and jump together: halt wins, pc unchanged
    bus_a.halt_req = 1'b1;
    bus_a.jump_en = 1'b1;
    bus_a.jump_target = 8'h80;
    tick();
    bus_a.halt_req = 1'b0;
    bus_a.jump_en = 1'b0;
    chk("hlt_halted", 32'(bus_a.halted),      32'd1);
    chk("hlt_valid",  32'(bus_a.instr_valid), 32'd0);
    chk("hlt_addr",   32'(bus_a.rom_addr),    32'h41);
    chk("hlt_cnt",    32'(bus_a.fetch_count), 32'd5);
    tick();
    chk("hlt_hold",     32'(bus_a.halted),      32'd1);
    chk("hlt_hold_cnt", 32'(bus_a.fetch_count), 32'd5);

    // Jump out of HALTED near the top of the address space, then wrap 0xFF -> 0
    bus_a.jump_en = 1'b1;
    bus_a.jump_target = 8'hFE;
    tick();
    bus_a.jump_en = 1'b0;
    chk("unhalt",      32'(bus_a.halted),   32'd0);
    chk("unhalt_addr", 32'(bus_a.rom_addr), 32'hFE);
    tick();
    chk("fe_instr", 32'(bus_a.instr),    32'h0E);
    chk("fe_addr",  32'(bus_a.rom_addr), 32'hFF);
    tick();
    chk("ff_instr", 32'(bus_a.instr),    32'h0F);
    chk("ff_pc",    32'(bus_a.instr_pc), 32'hFF);
    chk("wrap_addr", 32'(bus_a.rom_addr), 32'h00);
    tick();
    chk("w0_instr", 32'(bus_a.instr),       32'h10);
    chk("w0_cnt",   32'(bus_a.fetch_count), 32'd8);

    // Pause: FETCH -> IDLE, no fetch, pending instr consumed
    bus_a.run = 1'b0;
    tick();
    chk("pause_cnt",   32'(bus_a.fetch_count), 32'd8);
    chk("pause_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("pause_addr",  32'(bus_a.rom_addr),    32'h01);
    tick();
    chk("pause_cnt2", 32'(bus_a.fetch_count), 32'd8);
    bus_a.run = 1'b1;
    tick();
    chk("resume_cnt", 32'(bus_a.fetch_count), 32'd8);
    tick();
    chk("resume_instr", 32'(bus_a.instr),       32'h11);
    chk("resume_cnt2",  32'(bus_a.fetch_count), 32'd9);

    // Run up to pc 0x25, then reset asynchronously mid-cycle
    bus_a.jump_en = 1'b1;
    bus_a.jump_target = 8'h20;
    tick();
    bus_a.jump_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_addr",  32'(bus_a.rom_addr),    32'h25);
    chk("pre_rst_cnt",   32'(bus_a.fetch_count), 32'd14);
    chk("pre_rst_instr", 32'(bus_a.instr),       32'h34);
    #2;
    rst_a = 1'b0;
    #1;
    chk("arst_addr",  32'(bus_a.rom_addr),    32'h00);
    chk("arst_instr", 32'(bus_a.instr),       32'h00);
    chk("arst_cnt",   32'(bus_a.fetch_count), 32'd0);
    chk("arst_valid", 32'(bus_a.instr_valid), 32'd0);
    #2;
    rst_a = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus_a.instr_valid), 32'd0);
    tick();
    chk("post_rst_instr", 32'(bus_a.instr),       32'h10);
    chk("post_rst_pc",    32'(bus_a.instr_pc),    32'h00);
    chk("post_rst_cnt",   32'(bus_a.fetch_count), 32'd1);

    // WRAP=0, LAST_ADDR=3: fetch 0..3 then END
    rst_b = 1'b1;
    bus_b.run = 1'b1;
    bus_b.instr_ready = 1'b1;
    tick();
    chk("b_enter_cnt", 32'(bus_b.fetch_count), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("b_f2_halted", 32'(bus_b.halted),   32'd0);
    chk("b_f2_addr",   32'(bus_b.rom_addr), 32'h03);
    tick();
    chk("b_end_halted", 32'(bus_b.halted),      32'd1);
    chk("b_end_addr",   32'(bus_b.rom_addr),    32'h03);
    chk("b_end_cnt",    32'(bus_b.fetch_count), 32'd4);
    chk("b_end_instr",  32'(bus_b.instr),       32'h13);
    chk("b_end_valid",  32'(bus_b.instr_valid), 32'd1);
    tick();
    chk("b_end_consumed", 32'(bus_b.instr_valid), 32'd0);
    chk("b_end_cnt2",     32'(bus_b.fetch_count), 32'd4);
    chk("b_end_halted2",  32'(bus_b.halted),      32'd1);
    tick();
    chk("b_end_cnt3", 32'(bus_b.fetch_count), 32'd4);
    bus_b.jump_en = 1'b1;
    bus_b.jump_target = 8'h00;
    tick();
    bus_b.jump_en = 1'b0;
    chk("b_restart_halted", 32'(bus_b.halted),   32'd0);
    chk("b_restart_addr",   32'(bus_b.rom_addr), 32'h00);
    tick();
    chk("b_restart_instr", 32'(bus_b.instr),       32'h10);
    chk("b_restart_cnt",   32'(bus_b.fetch_count), 32'd5);
    chk("b_restart_addr2", 32'(bus_b.rom_addr),    32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
